// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and controller states.
package serial_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl, including the FSM state for debug.
// Handshake: Run is a request accepted on any edge where Busy=0; Done pulses
// for one cycle when Sum/C_out are valid; Run during Busy is dropped.
interface serial_add_ctrl_if #(parameter int NIBBLES = 4);
  import serial_add_pkg::*;

  localparam int W = SLICE_W * NIBBLES;

  logic         Run;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C_in;
  logic [W-1:0] Sum;
  logic         C_out;
  logic         Busy;
  logic         Done;
  logic [1:0]   State;

  modport master (
    output Run, A, B, C_in,
    input  Sum, C_out, Busy, Done, State
  );

  modport slave (
    input  Run, A, B, C_in,
    output Sum, C_out, Busy, Done, State
  );

endinterface

// File: rtl/nibble_adder.sv
// Purely combinational 4-bit adder slice with carry in/out.
module nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder: one 4-bit slice is reused for NIBBLES cycles, building
// Sum from the bottom nibble up and reporting the final carry on C_out.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  serial_add_ctrl_if.slave bus
);

  localparam int W    = SLICE_W * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ADD  = ADD;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]         r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [IDXW-1:0]    r_idx;

  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_s;
  logic               w_c;

  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_nib = r_a[i*SLICE_W +: SLICE_W];
        w_b_nib = r_b[i*SLICE_W +: SLICE_W];
      end
    end
  end

  nibble_adder u_slice (
    .a     (w_a_nib),
    .b     (w_b_nib),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_c)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // DONE accepts exactly like IDLE so back-to-back runs have no gap.
          if (bus.Run) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_carry <= bus.C_in;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_ADD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDXW'(i)) begin
              r_sum[i*SLICE_W +: SLICE_W] <= w_s;
            end
          end
          r_carry <= w_c;
          r_idx   <= r_idx + IDXW'(1);
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_c;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Sum   = r_sum;
  assign bus.C_out = r_cout;
  assign bus.Busy  = (r_state == S_ADD);
  assign bus.Done  = (r_state == S_DONE);
  assign bus.State = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: table of operand vectors plus
// hand-written back-to-back and mid-operation reset sequences.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         noise;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation; sampling is done on negedges, away from the active edge.
  task automatic run_op(input vec_t v, input string tag);
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    bus.A    = v.a;
    bus.B    = v.b;
    bus.C_in = v.cin;
    bus.Run  = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NIBBLES; k++) begin
      bus.Run  = v.noise && (k % 2 == 0);
      bus.A    = W'($urandom);
      bus.B    = W'($urandom);
      bus.C_in = 1'($urandom);
      check({tag, " busy"}, 32'(bus.Busy), 32'd1);
      check({tag, " state_add"}, 32'(bus.State), 32'(ADD));
      check({tag, " upper_zero"}, 32'(bus.Sum >> (4 * k)), 32'd0);
      if (bus.Done) done_cnt++;
      @(negedge clk);
    end
    if (bus.Done) done_cnt++;
    check({tag, " done"}, 32'(bus.Done), 32'd1);
    check({tag, " busy_off"}, 32'(bus.Busy), 32'd0);
    check({tag, " sum"}, 32'(bus.Sum), 32'(v.sum));
    check({tag, " cout"}, 32'(bus.C_out), 32'(v.cout));
    bus.Run = 1'b0;
    @(negedge clk);
    if (bus.Done) done_cnt++;
    check({tag, " idle"}, 32'(bus.State), 32'(IDLE));
    check({tag, " sum_hold"}, 32'(bus.Sum), 32'(v.sum));
    check({tag, " cout_hold"}, 32'(bus.C_out), 32'(v.cout));
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int done_cnt;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[3] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h9999, 16'h6667, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

    bus.Run  = 1'b0;
    bus.A    = '0;
    bus.B    = '0;
    bus.C_in = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("rst sum", 32'(bus.Sum), 32'd0);
      check("rst cout", 32'(bus.C_out), 32'd0);
      check("rst busy", 32'(bus.Busy), 32'd0);
      check("rst done", 32'(bus.Done), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: Run held high across DONE; second operands present at DONE edge.
    @(negedge clk);
    bus.A = 16'h00FF; bus.B = 16'h0001; bus.C_in = 1'b0; bus.Run = 1'b1;
    @(negedge clk);
    bus.A = 16'h8000; bus.B = 16'h8000;
    for (int k = 0; k < NIBBLES; k++) begin
      check("b2b busy1", 32'(bus.Busy), 32'd1);
      @(negedge clk);
    end
    check("b2b done1", 32'(bus.Done), 32'd1);
    check("b2b sum1", 32'(bus.Sum), 32'h0100);
    check("b2b cout1", 32'(bus.C_out), 32'd0);
    @(negedge clk);
    bus.Run = 1'b0;
    check("b2b no_idle", 32'(bus.State), 32'(ADD));
    check("b2b sum_clr", 32'(bus.Sum), 32'd0);
    for (int k = 0; k < NIBBLES; k++) begin
      check("b2b busy2", 32'(bus.Busy), 32'd1);
      @(negedge clk);
    end
    check("b2b done2", 32'(bus.Done), 32'd1);
    check("b2b sum2", 32'(bus.Sum), 32'h0000);
    check("b2b cout2", 32'(bus.C_out), 32'd1);
    @(negedge clk);
    check("b2b idle", 32'(bus.State), 32'(IDLE));

    // Reset landing on the second ADD edge aborts with no Done pulse.
    bus.A = 16'h1234; bus.B = 16'h4321; bus.C_in = 1'b1; bus.Run = 1'b1;
    @(negedge clk);
    bus.Run = 1'b0;
    @(negedge clk);
    check("mid sum_nib0", 32'(bus.Sum), 32'h0006);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid state", 32'(bus.State), 32'(IDLE));
    check("mid sum", 32'(bus.Sum), 32'd0);
    check("mid cout", 32'(bus.C_out), 32'd0);
    check("mid busy", 32'(bus.Busy), 32'd0);
    check("mid done", 32'(bus.Done), 32'd0);
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.Done) done_cnt++;
    end
    check("mid no_done", 32'(done_cnt), 32'd0);
    run_op(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit slices (W = 4*NIBBLES).
REQ-002 The block SHALL have port Clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port Run, input, 1, start request; sampled on each rising Clk edge.
REQ-005 The block SHALL have port A, input, W, operand A; sampled only on the start-accepting edge.
REQ-006 The block SHALL have port B, input, W, operand B; sampled only on the start-accepting edge.
REQ-007 The block SHALL have port C_in, input, 1, carry-in to nibble 0; sampled only on the start-accepting edge.
REQ-008 The block SHALL have port Sum, output, W, registered result.
REQ-009 The block SHALL have port C_out, output, 1, registered carry out of the top nibble.
REQ-010 The block SHALL have port Busy, output, 1, high while an addition is in progress.
REQ-011 The block SHALL have port Done, output, 1, one-cycle pulse marking Sum/C_out valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ADD, DONE.
REQ-013 In IDLE, an edge with Run=1 SHALL latch A, B and C_in, clear the nibble index to 0, clear Sum, and move to ADD.
REQ-014 An edge with Run=0 in IDLE SHALL leave all state unchanged.
REQ-015 On each edge in ADD, the block SHALL add nibble[idx] of the latched A and B plus the carry register, write the 4-bit result into Sum[4*idx+3:4*idx], store the slice carry into the carry register, and increment idx.
REQ-016 On the ADD edge where idx = NIBBLES-1, the block SHALL load C_out with the slice carry and move to DONE.
REQ-017 An accepted Run edge SHALL be followed by Done=1 visible after exactly NIBBLES further edges (4 edges at the default NIBBLES).
REQ-018 Done SHALL be high only while in DONE, for exactly one cycle.
REQ-019 Busy SHALL be high exactly while in ADD.
REQ-020 From DONE, an edge with Run=1 SHALL accept a new operation exactly as IDLE does, giving back-to-back operation with no idle gap.
REQ-021 From DONE, an edge with Run=0 SHALL move the block to IDLE.
REQ-022 Run asserted while in ADD SHALL be ignored: it is neither queued nor allowed to alter the latched operands.
REQ-023 Sum and C_out SHALL hold their final values in DONE and IDLE until the next accepted Run.
REQ-024 Sum bits above the current nibble SHALL read 0 while in ADD.
REQ-025 Arithmetic SHALL be modulo 2^W, with the overflow reported only on C_out.
REQ-026 Changes on A, B or C_in after acceptance SHALL have no effect on the result.

Reset
REQ-027 Reset=1 on any edge SHALL force the state to IDLE and clear Sum, C_out, Busy, Done, idx, the carry register and the operand registers to 0, overriding Run.
REQ-028 Reset asserted mid-ADD SHALL abort the operation with no Done pulse.
REQ-029 Reset SHALL take effect only on a clock edge; asynchronous behaviour is not permitted.

Structure
REQ-030 The state enum (IDLE/ADD/DONE) and the slice width constant 4 SHALL live in the shared package serial_add_pkg.
REQ-031 The block SHALL instantiate exactly one purely combinational 4-bit adder slice sub-module, nibble_adder (inputs a[3:0], b[3:0], c_in; outputs s[3:0], c_out), reused on every ADD cycle.
REQ-032 The controller SHALL contain no W-wide adder.

Verification
REQ-033 After reset, with Run held at 0 for 10 cycles, the bench SHALL check Sum=0, C_out=0, Busy=0 and Done=0 throughout.
REQ-034 With A=16'h1234, B=16'h4321, C_in=0 and a 1-cycle Run, the bench SHALL check Busy high for 4 cycles, Done after 4 edges, Sum=16'h5555 and C_out=0.
REQ-035 With A=16'hFFFF, B=16'h0000, C_in=1, the bench SHALL check that the carry ripples across all nibbles, giving Sum=16'h0000 and C_out=1.
REQ-036 With back-to-back operations (Run held high: 16'h00FF+16'h0001, then 16'h8000+16'h8000), the bench SHALL check Sum=16'h0100 with C_out=0, then Sum=16'h0000 with C_out=1, and no IDLE cycle between them.
REQ-037 With Run pulsed and operands changed during ADD, the bench SHALL check that the result equals the originally latched operands and that exactly one Done pulse occurs.
REQ-038 With Reset asserted on the second ADD edge, the bench SHALL check next-cycle IDLE, all outputs 0 and no Done pulse; a fresh Run SHALL then complete correctly.
